// File: rtl/bus5_to_32_decoder_pkg.sv
// Shared bus-select definitions: source codes, widths, FSM encodings and small helpers.
// Used by the bus decoder, its interface, and the select encoder / control unit.
package bus5_to_32_decoder_pkg;

    localparam int NUM_SRC = 24;
    localparam int SEL_W   = 5;

    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_SRC-1:0] src_vec_t;

    localparam sel_t SEL_R0     = 5'd0;
    localparam sel_t SEL_R1     = 5'd1;
    localparam sel_t SEL_R2     = 5'd2;
    localparam sel_t SEL_R3     = 5'd3;
    localparam sel_t SEL_R4     = 5'd4;
    localparam sel_t SEL_R5     = 5'd5;
    localparam sel_t SEL_R6     = 5'd6;
    localparam sel_t SEL_R7     = 5'd7;
    localparam sel_t SEL_R8     = 5'd8;
    localparam sel_t SEL_R9     = 5'd9;
    localparam sel_t SEL_R10    = 5'd10;
    localparam sel_t SEL_R11    = 5'd11;
    localparam sel_t SEL_R12    = 5'd12;
    localparam sel_t SEL_R13    = 5'd13;
    localparam sel_t SEL_R14    = 5'd14;
    localparam sel_t SEL_R15    = 5'd15;
    localparam sel_t SEL_HI     = 5'd16;
    localparam sel_t SEL_LO     = 5'd17;
    localparam sel_t SEL_ZHI    = 5'd18;
    localparam sel_t SEL_ZLO    = 5'd19;
    localparam sel_t SEL_PC     = 5'd20;
    localparam sel_t SEL_MDR    = 5'd21;
    localparam sel_t SEL_INPORT = 5'd22;
    localparam sel_t SEL_C      = 5'd23;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    function automatic logic sel_legal(input sel_t code);
        return code < sel_t'(NUM_SRC);
    endfunction

endpackage

// File: rtl/bus5_to_32_decoder_if.sv
// Select handshake between the control unit (master) and the bus select decoder (slave).
interface bus5_to_32_decoder_if;
    import bus5_to_32_decoder_pkg::*;

    logic     req;
    sel_t     sel;
    src_vec_t out_en;
    sel_t     cur_code;
    logic     busy;
    logic     ack;
    logic     err;

    modport master (
        output req,
        output sel,
        input  out_en,
        input  cur_code,
        input  busy,
        input  ack,
        input  err
    );

    modport slave (
        input  req,
        input  sel,
        output out_en,
        output cur_code,
        output busy,
        output ack,
        output err
    );

endinterface

// File: rtl/bus5_to_32_decoder_onehot_dec.sv
// Combinational source-code to one-hot decoder; codes outside the source range decode to zero.
module onehot_dec
    import bus5_to_32_decoder_pkg::*;
(
    input  sel_t     code,
    output src_vec_t onehot
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            onehot[k] = (code == sel_t'(k));
        end
    end

endmodule

// File: rtl/bus5_to_32_decoder.sv
// Registered bus source select decoder with minimum drive time and turnaround gap.
// Optional BUS_DEC_ONEHOT_CHK_EN adds a sticky chk_err output and a one-hot assertion.
//
//  state    | meaning
//  ---------+----------------------------------------------------------
//  ST_IDLE  | bus released, grant decision every cycle
//  ST_DRIVE | out_en = onehot(cur_code), hold counter running
//  ST_TURN  | out_en = 0 dead gap, grant decision on the last cycle
module bus5_to_32_decoder
    import bus5_to_32_decoder_pkg::*;
#(
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 1
)
(
    input  logic                  clk,
    input  logic                  clr,
    bus5_to_32_decoder_if.slave   bus
`ifdef BUS_DEC_ONEHOT_CHK_EN
    ,
    output logic                  chk_err
`endif
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int TURN_W = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TURN_W-1:0] TURN_LOAD = TURN_W'(TURN_CYCLES - 1);

    state_t            state_q,    state_nxt;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_nxt;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_nxt;
    src_vec_t          out_en_q,   out_en_nxt;
    sel_t              code_q,     code_nxt;
    logic              busy_q,     busy_nxt;
    logic              ack_q,      ack_nxt;
    logic              err_q,      err_nxt;

    logic     decide;
    logic     grant;
    logic     release_ok;
    sel_t     dec_code;
    src_vec_t dec_onehot;

    // Grant decisions happen in IDLE and on the final TURN cycle only.
    assign decide     = (state_q == ST_IDLE) ||
                        ((state_q == ST_TURN) && (turn_cnt_q == '0));
    assign grant      = decide && bus.req && sel_legal(bus.sel);
    assign release_ok = (hold_cnt_q == '0) && (!bus.req || (bus.sel != code_q));
    assign dec_code   = grant ? bus.sel : code_q;

    onehot_dec u_onehot_dec (
        .code   (dec_code),
        .onehot (dec_onehot)
    );

    always_comb begin
        state_nxt    = state_q;
        hold_cnt_nxt = hold_cnt_q;
        turn_cnt_nxt = turn_cnt_q;
        code_nxt     = code_q;
        out_en_nxt   = '0;
        busy_nxt     = 1'b0;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_nxt = ST_IDLE;
            end
            ST_DRIVE: begin
                busy_nxt = 1'b1;
                if (hold_cnt_q != '0) begin
                    hold_cnt_nxt = hold_cnt_q - 1'b1;
                end
                if (release_ok) begin
                    state_nxt    = ST_TURN;
                    turn_cnt_nxt = TURN_LOAD;
                end else begin
                    out_en_nxt = dec_onehot;
                end
            end
            ST_TURN: begin
                if (turn_cnt_q != '0) begin
                    turn_cnt_nxt = turn_cnt_q - 1'b1;
                    busy_nxt     = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        if (decide) begin
            if (grant) begin
                state_nxt    = ST_DRIVE;
                code_nxt     = bus.sel;
                out_en_nxt   = dec_onehot;
                busy_nxt     = 1'b1;
                ack_nxt      = 1'b1;
                hold_cnt_nxt = HOLD_LOAD;
            end else begin
                state_nxt = ST_IDLE;
                err_nxt   = bus.req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            hold_cnt_q <= '0;
            turn_cnt_q <= '0;
            out_en_q   <= '0;
            code_q     <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            hold_cnt_q <= hold_cnt_nxt;
            turn_cnt_q <= turn_cnt_nxt;
            out_en_q   <= out_en_nxt;
            code_q     <= code_nxt;
            busy_q     <= busy_nxt;
            ack_q      <= ack_nxt;
            err_q      <= err_nxt;
        end
    end

    assign bus.out_en   = out_en_q;
    assign bus.cur_code = code_q;
    assign bus.busy     = busy_q;
    assign bus.ack      = ack_q;
    assign bus.err      = err_q;

`ifdef BUS_DEC_ONEHOT_CHK_EN
    logic multi_hot;
    logic stray_drive;
    logic chk_err_q;

    assign multi_hot   = (out_en_q & (out_en_q - src_vec_t'(1))) != '0;
    assign stray_drive = (out_en_q != '0) && (state_q != ST_DRIVE);

    always_ff @(posedge clk) begin
        if (clr) begin
            chk_err_q <= 1'b0;
        end else if (multi_hot || stray_drive) begin
            chk_err_q <= 1'b1;
        end
    end

    assign chk_err = chk_err_q;

    a_out_en_onehot0: assert property (@(posedge clk) disable iff (clr)
        $onehot0(out_en_q) && ((out_en_q == '0) || (state_q == ST_DRIVE)))
        else $error("bus decoder drove overlapping or stray out_en %h", out_en_q);
`endif

endmodule

// File: tb/tb_bus5_to_32_decoder.sv
// Directed bench for the bus select decoder: default instance plus a HOLD_CYCLES=3 instance.
`timescale 1ns/1ps
module tb_bus5_to_32_decoder;
    import bus5_to_32_decoder_pkg::*;

    logic clk;
    logic clr;
    int   checks;
    int   errors;

    bus5_to_32_decoder_if b0 ();
    bus5_to_32_decoder_if b3 ();

`ifdef BUS_DEC_ONEHOT_CHK_EN
    logic chk_err0;
    logic chk_err3;
`endif

    bus5_to_32_decoder #(.HOLD_CYCLES(1), .TURN_CYCLES(1)) dut (
        .clk (clk),
        .clr (clr),
        .bus (b0.slave)
`ifdef BUS_DEC_ONEHOT_CHK_EN
        ,
        .chk_err (chk_err0)
`endif
    );

    bus5_to_32_decoder #(.HOLD_CYCLES(3), .TURN_CYCLES(1)) dut3 (
        .clk (clk),
        .clr (clr),
        .bus (b3.slave)
`ifdef BUS_DEC_ONEHOT_CHK_EN
        ,
        .chk_err (chk_err3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        b0.req = 1'b0; b0.sel = '0;
        b3.req = 1'b0; b3.sel = '0;
        tick(); tick();
        checks++; if (b0.out_en !== 24'h0) begin errors++; $display("FAIL reset_out_en got %h want %h", b0.out_en, 24'h0); end
        checks++; if (b0.cur_code !== 5'd0) begin errors++; $display("FAIL reset_cur_code got %0d want 0", b0.cur_code); end
        checks++; if ({b0.busy, b0.ack, b0.err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {b0.busy, b0.ack, b0.err}); end
        checks++; if ({b3.out_en, b3.busy} !== 25'h0) begin errors++; $display("FAIL reset_dut3 got %h want 0", {b3.out_en, b3.busy}); end
        clr = 1'b0;
        tick();
    endtask

    task automatic test_basic_grant();
        b0.req = 1'b1; b0.sel = SEL_PC;
        tick();
        checks++; if (b0.out_en !== 24'h100000) begin errors++; $display("FAIL grant_out_en got %h want %h", b0.out_en, 24'h100000); end
        checks++; if (b0.cur_code !== 5'd20) begin errors++; $display("FAIL grant_cur_code got %0d want 20", b0.cur_code); end
        checks++; if ({b0.ack, b0.busy} !== 2'b11) begin errors++; $display("FAIL grant_ack_busy got %b want 11", {b0.ack, b0.busy}); end
        b0.req = 1'b0;
        tick();
        checks++; if ({b0.out_en, b0.busy} !== {24'h0, 1'b1}) begin errors++; $display("FAIL grant_turn got %h/%b want 0/1", b0.out_en, b0.busy); end
        tick();
        checks++; if (b0.busy !== 1'b0) begin errors++; $display("FAIL grant_idle_busy got %b want 0", b0.busy); end
    endtask

    task automatic test_hold_release();
        b0.req = 1'b1; b0.sel = SEL_R5;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (b0.out_en !== 24'h000020) begin errors++; $display("FAIL hold_out_en cyc %0d got %h want %h", i, b0.out_en, 24'h000020); end
            checks++; if (b0.ack !== (i == 0)) begin errors++; $display("FAIL hold_ack cyc %0d got %b want %b", i, b0.ack, (i == 0)); end
        end
        b0.req = 1'b0;
        tick();
        checks++; if ({b0.out_en, b0.busy} !== {24'h0, 1'b1}) begin errors++; $display("FAIL hold_turn got %h/%b want 0/1", b0.out_en, b0.busy); end
        tick();
        checks++; if ({b0.out_en, b0.busy} !== 25'h0) begin errors++; $display("FAIL hold_idle got %h/%b want 0/0", b0.out_en, b0.busy); end
    endtask

    task automatic test_switch();
        b0.req = 1'b1; b0.sel = SEL_R3;
        tick();
        checks++; if ({b0.out_en, b0.ack} !== {24'h000008, 1'b1}) begin errors++; $display("FAIL sw_first got %h/%b want 000008/1", b0.out_en, b0.ack); end
        tick();
        checks++; if ({b0.out_en, b0.ack} !== {24'h000008, 1'b0}) begin errors++; $display("FAIL sw_hold got %h/%b want 000008/0", b0.out_en, b0.ack); end
        b0.sel = SEL_LO;
        tick();
        checks++; if ({b0.out_en, b0.busy} !== {24'h0, 1'b1}) begin errors++; $display("FAIL sw_gap got %h/%b want 0/1", b0.out_en, b0.busy); end
        tick();
        checks++; if ({b0.out_en, b0.ack} !== {24'h020000, 1'b1}) begin errors++; $display("FAIL sw_second got %h/%b want 020000/1", b0.out_en, b0.ack); end
        checks++; if (b0.cur_code !== 5'd17) begin errors++; $display("FAIL sw_cur_code got %0d want 17", b0.cur_code); end
        b0.req = 1'b0;
        tick();
        checks++; if (b0.out_en !== 24'h0) begin errors++; $display("FAIL sw_release got %h want 0", b0.out_en); end
        tick();
    endtask

    task automatic test_illegal();
        b0.req = 1'b1; b0.sel = 5'd27;
        tick();
        checks++; if ({b0.err, b0.busy, b0.ack} !== 3'b100) begin errors++; $display("FAIL ill27_flags got %b want 100", {b0.err, b0.busy, b0.ack}); end
        checks++; if (b0.out_en !== 24'h0) begin errors++; $display("FAIL ill27_out_en got %h want 0", b0.out_en); end
        b0.sel = 5'd31;
        tick();
        checks++; if ({b0.err, b0.busy, b0.out_en} !== {1'b1, 1'b0, 24'h0}) begin errors++; $display("FAIL ill31 got err %b busy %b out %h want 1/0/0", b0.err, b0.busy, b0.out_en); end
        b0.req = 1'b0;
        tick();
        checks++; if (b0.err !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", b0.err); end
    endtask

    task automatic test_hold3();
        b3.req = 1'b1; b3.sel = SEL_R9;
        tick();
        checks++; if ({b3.out_en, b3.ack} !== {24'h000200, 1'b1}) begin errors++; $display("FAIL h3_first got %h/%b want 000200/1", b3.out_en, b3.ack); end
        b3.req = 1'b0; b3.sel = SEL_R4;
        for (int i = 1; i < 3; i++) begin
            tick();
            checks++; if ({b3.out_en, b3.ack, b3.cur_code} !== {24'h000200, 1'b0, 5'd9}) begin errors++; $display("FAIL h3_hold cyc %0d got %h/%b/%0d want 000200/0/9", i, b3.out_en, b3.ack, b3.cur_code); end
        end
        tick();
        checks++; if ({b3.out_en, b3.busy} !== {24'h0, 1'b1}) begin errors++; $display("FAIL h3_turn got %h/%b want 0/1", b3.out_en, b3.busy); end
        tick();
        checks++; if (b3.busy !== 1'b0) begin errors++; $display("FAIL h3_idle got %b want 0", b3.busy); end
    endtask

    task automatic test_back_to_back_same();
        b0.req = 1'b1; b0.sel = SEL_R7;
        tick();
        checks++; if ({b0.out_en, b0.ack} !== {24'h000080, 1'b1}) begin errors++; $display("FAIL same_first got %h/%b want 000080/1", b0.out_en, b0.ack); end
        b0.req = 1'b0;
        tick();
        checks++; if (b0.out_en !== 24'h0) begin errors++; $display("FAIL same_gap got %h want 0", b0.out_en); end
        b0.req = 1'b1;
        tick();
        checks++; if ({b0.out_en, b0.ack} !== {24'h000080, 1'b1}) begin errors++; $display("FAIL same_again got %h/%b want 000080/1", b0.out_en, b0.ack); end
        b0.req = 1'b0;
        tick(); tick();
    endtask

    task automatic test_clr_mid_drive();
        b0.req = 1'b1; b0.sel = SEL_R0;
        tick(); tick();
        checks++; if (b0.out_en !== 24'h000001) begin errors++; $display("FAIL clr_pre got %h want 000001", b0.out_en); end
        clr = 1'b1;
        tick();
        checks++; if ({b0.out_en, b0.busy, b0.ack} !== {24'h0, 2'b00}) begin errors++; $display("FAIL clr_mid got %h/%b/%b want 0/0/0", b0.out_en, b0.busy, b0.ack); end
        clr = 1'b0; b0.req = 1'b0;
        tick();
        checks++; if ({b0.out_en, b0.busy} !== 25'h0) begin errors++; $display("FAIL clr_after got %h/%b want 0/0", b0.out_en, b0.busy); end
`ifdef BUS_DEC_ONEHOT_CHK_EN
        checks++; if ({chk_err0, chk_err3} !== 2'b00) begin errors++; $display("FAIL chk_err got %b want 00", {chk_err0, chk_err3}); end
`endif
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_grant();
        test_hold_release();
        test_switch();
        test_illegal();
        test_hold3();
        test_back_to_back_same();
        test_clr_mid_drive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
